cdb_arbiter: RTL and testbench

Merges the ALU and LSB result streams onto a single registered common data bus (CDB). The CDB feeds ROB, RS and LSB wakeup, so those blocks need one result port instead of two. Sits between the `alu`/`LSB` producers and the `ROB`/`RS`/`LSB` consumers. Contains a small per-source FIFO with a same-cycle bypass, round-robin grant, producer backpressure and flush on `roll`.

---
 rtl/cdb_arbiter_pkg.sv | 19 +
 rtl/cdb_fifo.sv | 66 ++++++
 rtl/cdb_arbiter.sv | 132 +++++++++++++
 tb/tb_cdb_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter: field widths, source encoding
// and the packed FIFO entry width.
package cdb_arbiter_pkg;

  localparam int unsigned ROB_INDEX_RANGE = 4;
  localparam int unsigned VAL_W           = 32;
  localparam int unsigned PC_W            = 32;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

  // FIFO entry layout: {idx, val, jump_flag, jump_PC}
  function automatic int unsigned entry_w(input int unsigned rob_w);
    return rob_w + VAL_W + 1 + PC_W;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO with flush; a push into a full FIFO is dropped unless a pop
// frees a slot in the same cycle, and the dropped push is reported on ovf.
module cdb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~do_pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Merges ALU and LSB results onto one registered CDB with per-source FIFOs,
// same-cycle bypass, round-robin grant, backpressure and flush on roll.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned ROB_W = ROB_INDEX_RANGE,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             roll,
  input  logic             ALU_flag,
  input  logic [ROB_W-1:0] ALU_ROB_idx,
  input  logic [31:0]      ALU_val,
  input  logic             ALU_jump_flag,
  input  logic [31:0]      ALU_jump_PC,
  input  logic             LSB_flag,
  input  logic [ROB_W-1:0] LSB_ROB_idx,
  input  logic [31:0]      LSB_val,
  output logic             ALU_stall,
  output logic             LSB_stall,
  output logic             CDB_flag,
  output logic [ROB_W-1:0] CDB_ROB_idx,
  output logic [31:0]      CDB_val,
  output logic             CDB_src,
  output logic             CDB_jump_flag,
  output logic [31:0]      CDB_jump_PC,
  output logic             ovf_err
);

  localparam int unsigned EW = entry_w(ROB_W);

  logic [EW-1:0] alu_live, lsb_live;
  logic [EW-1:0] alu_head, lsb_head;
  logic [EW-1:0] alu_cand, lsb_cand, win_entry;
  logic          alu_empty, lsb_empty, alu_full, lsb_full;
  logic          alu_ovf, lsb_ovf;
  logic          alu_pend, lsb_pend;
  logic          active, flush, grant;
  logic          alu_push, lsb_push, alu_pop, lsb_pop;
  logic          alu_bypass, lsb_bypass;
  cdb_src_e      winner, last_grant, src_q;

  assign active = rdy & ~roll;
  assign flush  = rdy & roll;

  assign alu_live = {ALU_ROB_idx, ALU_val, ALU_jump_flag, ALU_jump_PC};
  assign lsb_live = {LSB_ROB_idx, LSB_val, 1'b0, PC_W'(0)};

  assign alu_cand = alu_empty ? alu_live : alu_head;
  assign lsb_cand = lsb_empty ? lsb_live : lsb_head;

  assign alu_pend = ~alu_empty | ALU_flag;
  assign lsb_pend = ~lsb_empty | LSB_flag;

  always_comb begin
    winner = CDB_SRC_ALU;
    if (alu_pend && lsb_pend) begin
      winner = (last_grant == CDB_SRC_LSB) ? CDB_SRC_ALU : CDB_SRC_LSB;
    end else if (lsb_pend) begin
      winner = CDB_SRC_LSB;
    end
  end

  assign grant     = active & (alu_pend | lsb_pend);
  assign win_entry = (winner == CDB_SRC_ALU) ? alu_cand : lsb_cand;

  // A live input bypasses only when its FIFO is empty and it wins; otherwise it enqueues.
  assign alu_bypass = grant & (winner == CDB_SRC_ALU) & alu_empty;
  assign lsb_bypass = grant & (winner == CDB_SRC_LSB) & lsb_empty;
  assign alu_pop    = grant & (winner == CDB_SRC_ALU) & ~alu_empty;
  assign lsb_pop    = grant & (winner == CDB_SRC_LSB) & ~lsb_empty;
  assign alu_push   = active & ALU_flag & ~alu_bypass;
  assign lsb_push   = active & LSB_flag & ~lsb_bypass;

  cdb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (alu_push),
    .pop   (alu_pop),
    .din   (alu_live),
    .head  (alu_head),
    .empty (alu_empty),
    .full  (alu_full),
    .ovf   (alu_ovf)
  );

  cdb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (lsb_push),
    .pop   (lsb_pop),
    .din   (lsb_live),
    .head  (lsb_head),
    .empty (lsb_empty),
    .full  (lsb_full),
    .ovf   (lsb_ovf)
  );

  assign ALU_stall = alu_full;
  assign LSB_stall = lsb_full;
  assign CDB_src   = src_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      CDB_flag      <= 1'b0;
      CDB_ROB_idx   <= '0;
      CDB_val       <= '0;
      CDB_jump_flag <= 1'b0;
      CDB_jump_PC   <= '0;
      src_q         <= CDB_SRC_ALU;
      last_grant    <= CDB_SRC_LSB;
      ovf_err       <= 1'b0;
    end else if (rdy) begin
      if (alu_ovf || lsb_ovf) begin
        ovf_err <= 1'b1;
      end
      if (grant) begin
        CDB_flag <= 1'b1;
        {CDB_ROB_idx, CDB_val, CDB_jump_flag, CDB_jump_PC} <= win_entry;
        src_q      <= winner;
        last_grant <= winner;
      end else begin
        CDB_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a queue-based reference model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_cdb_arbiter;

  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] val;
    logic        jf;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, rdy, roll;
  logic        ALU_flag, ALU_jump_flag, LSB_flag;
  logic [3:0]  ALU_ROB_idx, LSB_ROB_idx;
  logic [31:0] ALU_val, ALU_jump_PC, LSB_val;
  logic        ALU_stall, LSB_stall, CDB_flag, CDB_src, CDB_jump_flag, ovf_err;
  logic [3:0]  CDB_ROB_idx;
  logic [31:0] CDB_val, CDB_jump_PC;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  cdb_arbiter #(.ROB_W(4), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .roll          (roll),
    .ALU_flag      (ALU_flag),
    .ALU_ROB_idx   (ALU_ROB_idx),
    .ALU_val       (ALU_val),
    .ALU_jump_flag (ALU_jump_flag),
    .ALU_jump_PC   (ALU_jump_PC),
    .LSB_flag      (LSB_flag),
    .LSB_ROB_idx   (LSB_ROB_idx),
    .LSB_val       (LSB_val),
    .ALU_stall     (ALU_stall),
    .LSB_stall     (LSB_stall),
    .CDB_flag      (CDB_flag),
    .CDB_ROB_idx   (CDB_ROB_idx),
    .CDB_val       (CDB_val),
    .CDB_src       (CDB_src),
    .CDB_jump_flag (CDB_jump_flag),
    .CDB_jump_PC   (CDB_jump_PC),
    .ovf_err       (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queues per source, rules applied once per rising edge.
  ent_t qa[$];
  ent_t ql[$];
  ent_t m_ent, m_la, m_ll;
  bit   m_valid = 0;
  bit   m_flag, m_src, m_last, m_ovf;
  bit   m_pa, m_pl, m_win, m_aused, m_lused;

  always @(posedge clk) begin
    if (!rst) begin
      qa.delete();
      ql.delete();
      m_flag  = 0;
      m_ent   = '0;
      m_src   = 0;
      m_last  = 1;
      m_ovf   = 0;
      m_valid = 1;
    end else if (rdy) begin
      if (roll) begin
        qa.delete();
        ql.delete();
        m_flag = 0;
      end else begin
        m_la    = '{ALU_ROB_idx, ALU_val, ALU_jump_flag, ALU_jump_PC};
        m_ll    = '{LSB_ROB_idx, LSB_val, 1'b0, 32'h0};
        m_pa    = (qa.size() != 0) || ALU_flag;
        m_pl    = (ql.size() != 0) || LSB_flag;
        m_aused = 0;
        m_lused = 0;
        if (m_pa || m_pl) begin
          m_win = (m_pa && m_pl) ? ~m_last : m_pl;
          if (!m_win) begin
            if (qa.size() != 0) m_ent = qa.pop_front();
            else begin m_ent = m_la; m_aused = 1; end
          end else begin
            if (ql.size() != 0) m_ent = ql.pop_front();
            else begin m_ent = m_ll; m_lused = 1; end
          end
          m_src  = m_win;
          m_last = m_win;
          m_flag = 1;
        end else begin
          m_flag = 0;
        end
        if (ALU_flag && !m_aused) begin
          if (qa.size() == DEPTH) m_ovf = 1;
          else qa.push_back(m_la);
        end
        if (LSB_flag && !m_lused) begin
          if (ql.size() == DEPTH) m_ovf = 1;
          else ql.push_back(m_ll);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("CDB_flag", CDB_flag, m_flag);
      chk("CDB_ROB_idx", CDB_ROB_idx, m_ent.idx);
      chk("CDB_val", CDB_val, m_ent.val);
      chk("CDB_src", CDB_src, m_src);
      chk("CDB_jump_flag", CDB_jump_flag, m_ent.jf);
      chk("CDB_jump_PC", CDB_jump_PC, m_ent.pc);
      chk("ALU_stall", ALU_stall, qa.size() == DEPTH);
      chk("LSB_stall", LSB_stall, ql.size() == DEPTH);
      chk("ovf_err", ovf_err, m_ovf);
    end
  end

  task automatic step(input bit af, input logic [3:0] ai, input logic [31:0] av,
                      input bit aj, input logic [31:0] ap,
                      input bit lf, input logic [3:0] li, input logic [31:0] lv);
    ALU_flag      = af;
    ALU_ROB_idx   = ai;
    ALU_val       = av;
    ALU_jump_flag = aj;
    ALU_jump_PC   = ap;
    LSB_flag      = lf;
    LSB_ROB_idx   = li;
    LSB_val       = lv;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 4'd0, 32'h0, 0, 32'h0, 0, 4'd0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) idle();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit af, lf;
    rst  = 1'b0;
    rdy  = 1'b1;
    roll = 1'b0;
    ALU_flag = 0; ALU_ROB_idx = 0; ALU_val = 0; ALU_jump_flag = 0; ALU_jump_PC = 0;
    LSB_flag = 0; LSB_ROB_idx = 0; LSB_val = 0;
    @(negedge clk);

    // Reset
    do_reset();
    chk("hand_reset_flag", CDB_flag, 0);
    chk("hand_reset_val", CDB_val, 0);
    chk("hand_reset_astall", ALU_stall, 0);
    chk("hand_reset_lstall", LSB_stall, 0);
    chk("hand_reset_ovf", ovf_err, 0);

    // Bypass
    step(1, 4'd3, 32'h1234, 1, 32'h100, 0, 4'd0, 32'h0);
    chk("hand_byp_flag", CDB_flag, 1);
    chk("hand_byp_idx", CDB_ROB_idx, 3);
    chk("hand_byp_val", CDB_val, 32'h1234);
    chk("hand_byp_src", CDB_src, 0);
    chk("hand_byp_jf", CDB_jump_flag, 1);
    chk("hand_byp_pc", CDB_jump_PC, 32'h100);
    idle();
    chk("hand_byp_flag_off", CDB_flag, 0);

    // Tie after reset: ALU first, then LSB
    do_reset();
    step(1, 4'd1, 32'h11, 0, 32'h0, 1, 4'd2, 32'h22);
    chk("hand_tie1_idx", CDB_ROB_idx, 1);
    chk("hand_tie1_src", CDB_src, 0);
    idle();
    chk("hand_tie2_flag", CDB_flag, 1);
    chk("hand_tie2_idx", CDB_ROB_idx, 2);
    chk("hand_tie2_src", CDB_src, 1);
    chk("hand_tie2_val", CDB_val, 32'h22);
    idle();

    // Saturation, producers honouring stall
    for (int i = 0; i < 10; i++) begin
      af = (qa.size() != DEPTH);
      lf = (ql.size() != DEPTH);
      step(af, 4'(i), 32'hA000 + 32'(i), i[0], 32'h200 + 32'(i),
           lf, 4'(i + 8), 32'hB000 + 32'(i));
      if (i == 0) chk("hand_sat0_src", CDB_src, 0);
      if (i == 1) chk("hand_sat1_src", CDB_src, 1);
      if (i == 2) chk("hand_sat2_lstall", LSB_stall, 1);
      if (i == 3) chk("hand_sat3_astall", ALU_stall, 1);
    end
    repeat (5) idle();
    chk("hand_sat_ovf", ovf_err, 0);

    // Flush with both FIFOs full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 4'(i), 32'hC000 + 32'(i), 0, 32'h0, 1, 4'(i + 4), 32'hD000 + 32'(i));
    end
    chk("hand_fl_astall", ALU_stall, 1);
    chk("hand_fl_lstall", LSB_stall, 1);
    chk("hand_fl_ovf", ovf_err, 0);
    roll = 1'b1;
    step(1, 4'd14, 32'hEEEE, 1, 32'h300, 1, 4'd15, 32'hFFFF);
    roll = 1'b0;
    chk("hand_fl_flag", CDB_flag, 0);
    chk("hand_fl_astall0", ALU_stall, 0);
    chk("hand_fl_lstall0", LSB_stall, 0);
    step(0, 4'd0, 32'h0, 0, 32'h0, 1, 4'd9, 32'h99);
    chk("hand_fl_new_flag", CDB_flag, 1);
    chk("hand_fl_new_src", CDB_src, 1);
    chk("hand_fl_new_idx", CDB_ROB_idx, 9);
    idle();
    chk("hand_fl_new_off", CDB_flag, 0);

    // Freeze
    step(1, 4'd4, 32'h44, 0, 32'h0, 1, 4'd5, 32'h55);
    chk("hand_fz_idx", CDB_ROB_idx, 4);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1, 4'd7, 32'h77, 1, 32'h7, 1, 4'd8, 32'h88);
      chk("hand_fz_hold_flag", CDB_flag, 1);
      chk("hand_fz_hold_idx", CDB_ROB_idx, 4);
      chk("hand_fz_hold_src", CDB_src, 0);
    end
    rdy = 1'b1;
    idle();
    chk("hand_fz_res_idx", CDB_ROB_idx, 5);
    chk("hand_fz_res_src", CDB_src, 1);
    idle();
    chk("hand_fz_res_off", CDB_flag, 0);

    // Overflow: both producers ignore stall
    for (int i = 0; i < 5; i++) begin
      step(1, 4'(i), 32'h5000 + 32'(i), 0, 32'h0, 1, 4'(i + 10), 32'h6000 + 32'(i));
    end
    chk("hand_ovf_set", ovf_err, 1);
    repeat (6) idle();
    chk("hand_ovf_sticky", ovf_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
